// File: rtl/stream_capture_framer_if.sv
// Sample-in / frame-out bus of the capture framer.
// The master side produces samples and consumes frames.
// The slave side (the framer) does the opposite.
interface stream_capture_framer_if #(
    parameter int DSIZE = 16,
    parameter int LANES = 4
) ();
    logic                   in_valid;
    logic [DSIZE-1:0]       in_data;
    logic                   in_ready;
    logic                   trigger;
    logic [LANES*DSIZE-1:0] frame_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  trigger,
        input  frame_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output trigger,
        output frame_data
    );
endinterface

// File: rtl/stream_capture_framer.sv
// Packs LANES consecutive samples into a frame and buffers frames in a small FIFO.
// Each buffered frame is emitted as a stable bus with a one-cycle trigger,
// at most one frame every two cycles.
// After TRIGGER_TOTAL frames the block parks in DONE until reset.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_RUN  | accepting samples and emitting frames
// ST_DONE | TRIGGER_TOTAL frames emitted; input closed, FIFO frozen
// EM_IDLE | emitter may pop the FIFO head on this cycle
// EM_PULSE| trigger high for the frame just popped; no pop allowed
module stream_capture_framer #(
    parameter int DSIZE         = 16,
    parameter int LANES         = 4,
    parameter int DEPTH         = 8,
    parameter int TRIGGER_TOTAL = 1000
) (
    input  logic                               clock,
    input  logic                               rst,
    input  logic                               enable,
    input  logic                               drain_en,
    stream_capture_framer_if.slave             bus,
    output logic [$clog2(DEPTH+1)-1:0]         fifo_level,
    output logic [$clog2(TRIGGER_TOTAL+1)-1:0] frame_cnt,
    output logic                               done
);
    localparam int LW  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int AW  = $clog2(DEPTH);
    localparam int LVW = $clog2(DEPTH + 1);
    localparam int CW  = $clog2(TRIGGER_TOTAL + 1);
    localparam int FW  = LANES * DSIZE;

    typedef enum logic {ST_RUN, ST_DONE} state_t;
    typedef enum logic {EM_IDLE, EM_PULSE} emit_t;

    state_t                      state_q, state_d;
    emit_t                       emit_q, emit_d;
    logic [LW-1:0]               lane_cnt_q, lane_cnt_d;
    logic [LANES-1:0][DSIZE-1:0] hold_q, hold_d;
    logic [LANES-1:0][DSIZE-1:0] push_frame;
    logic [FW-1:0]               mem_q [DEPTH];
    logic [FW-1:0]               mem_d [DEPTH];
    logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [LVW-1:0]              level_q, level_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [FW-1:0]               frame_q, frame_d;
    logic                        trigger_q, trigger_d;

    logic full, last_lane, accept, push, pop, enter_done;

    // The last lane is held off only when its completed frame has nowhere to go.
    // Lanes before it can still fill while the FIFO is full.
    assign full       = (level_q == LVW'(DEPTH));
    assign last_lane  = (lane_cnt_q == LW'(LANES - 1));
    assign bus.in_ready = !rst && enable && (state_q == ST_RUN) && !(last_lane && full);
    assign accept     = bus.in_valid && bus.in_ready;
    assign push       = accept && last_lane;
    assign pop        = (state_q == ST_RUN) && (emit_q == EM_IDLE) && drain_en && (level_q != '0);
    assign enter_done = pop && (cnt_q == CW'(TRIGGER_TOTAL - 1));

    // Packer and FIFO bookkeeping; a frame completes with the sample landing in the last lane.
    always_comb begin
        hold_d     = hold_q;
        lane_cnt_d = lane_cnt_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        push_frame = hold_q;
        push_frame[LANES-1] = bus.in_data;
        if (accept) begin
            hold_d[lane_cnt_q] = bus.in_data;
            lane_cnt_d = last_lane ? '0 : lane_cnt_q + LW'(1);
        end
        if (push) begin
            mem_d[wr_ptr_q] = push_frame;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        level_d = level_q + LVW'(push) - LVW'(pop);
        if (enter_done) begin
            lane_cnt_d = '0;
            hold_d     = '0;
        end
    end

    // Emitter and top state: a pop loads the frame bus and raises trigger for exactly one cycle.
    always_comb begin
        state_d   = state_q;
        emit_d    = EM_IDLE;
        trigger_d = 1'b0;
        frame_d   = frame_q;
        cnt_d     = cnt_q;
        if (pop) begin
            emit_d    = EM_PULSE;
            trigger_d = 1'b1;
            frame_d   = mem_q[rd_ptr_q];
            if (cnt_q != CW'(TRIGGER_TOTAL)) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        if (enter_done) begin
            state_d = ST_DONE;
        end
    end

    // Control and output registers; reset drops any pulse in flight and all buffered data.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            emit_q     <= EM_IDLE;
            lane_cnt_q <= '0;
            hold_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            cnt_q      <= '0;
            frame_q    <= '0;
            trigger_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            emit_q     <= emit_d;
            lane_cnt_q <= lane_cnt_d;
            hold_q     <= hold_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            cnt_q      <= cnt_d;
            frame_q    <= frame_d;
            trigger_q  <= trigger_d;
        end
    end

    // FIFO storage carries no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign bus.trigger    = trigger_q;
    assign bus.frame_data = frame_q;
    assign fifo_level     = level_q;
    assign frame_cnt      = cnt_q;
    assign done           = (state_q == ST_DONE);
endmodule

// File: tb/tb_stream_capture_framer.sv
// Bench for the capture framer: directed scenarios plus a randomized run,
// checked against a queue-based reference model of the framer.
// A second instance with a tiny FIFO and trigger total exercises completion.
module tb_stream_capture_framer;
    localparam int DSIZE    = 16;
    localparam int LANES    = 4;
    localparam int D1_DEPTH = 8;
    localparam int D1_TT    = 1000;
    localparam int D2_DEPTH = 2;
    localparam int D2_TT    = 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst1, en1, dr1, done1;
    logic [3:0] lvl1;
    logic [9:0] cnt1;
    logic rst2, en2, dr2, done2;
    logic [1:0] lvl2;
    logic [1:0] cnt2;

    stream_capture_framer_if #(.DSIZE(DSIZE), .LANES(LANES)) bus1 ();
    stream_capture_framer_if #(.DSIZE(DSIZE), .LANES(LANES)) bus2 ();

    stream_capture_framer #(.DSIZE(DSIZE), .LANES(LANES), .DEPTH(D1_DEPTH), .TRIGGER_TOTAL(D1_TT)) dut1 (
        .clock(clock), .rst(rst1), .enable(en1), .drain_en(dr1), .bus(bus1.slave),
        .fifo_level(lvl1), .frame_cnt(cnt1), .done(done1));

    stream_capture_framer #(.DSIZE(DSIZE), .LANES(LANES), .DEPTH(D2_DEPTH), .TRIGGER_TOTAL(D2_TT)) dut2 (
        .clock(clock), .rst(rst2), .enable(en2), .drain_en(dr2), .bus(bus2.slave),
        .fifo_level(lvl2), .frame_cnt(cnt2), .done(done2));

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: partial frame and FIFO as queues, emitter as a pulse flag.
    logic [DSIZE-1:0] m_part[$];
    logic [63:0]      m_fifo[$];
    bit               m_pulse, m_trig, m_done;
    logic [63:0]      m_frame;
    int               m_cnt;

    task automatic m_reset();
        m_part.delete();
        m_fifo.delete();
        m_pulse = 0; m_trig = 0; m_done = 0; m_frame = '0; m_cnt = 0;
    endtask

    function automatic bit m_ready(input logic en);
        return en && !m_done && !((m_part.size() == LANES - 1) && (m_fifo.size() == D1_DEPTH));
    endfunction

    task automatic m_step(input logic en, input logic dr, input logic v, input logic [DSIZE-1:0] d);
        bit acc, pop;
        logic [63:0] f;
        acc = v && m_ready(en);
        pop = !m_done && dr && !m_pulse && (m_fifo.size() > 0);
        m_trig  = pop;
        m_pulse = pop;
        if (pop) begin
            m_frame = m_fifo.pop_front();
            m_cnt++;
        end
        if (acc) begin
            m_part.push_back(d);
            if (m_part.size() == LANES) begin
                f = '0;
                for (int j = 0; j < LANES; j++) f[j*DSIZE +: DSIZE] = m_part[j];
                m_fifo.push_back(f);
                m_part.delete();
            end
        end
        if (m_cnt == D1_TT && !m_done) begin
            m_done = 1;
            m_part.delete();
        end
    endtask

    logic [63:0] obs[$];
    int  trig_seen = 0;
    int  acc_seen  = 0;
    int  cyc_no    = 0;
    bit  last_acc;

    // One clock of DUT1: drive, check in_ready, clock, check registered outputs.
    task automatic cyc1(input logic en, input logic dr, input logic v, input logic [DSIZE-1:0] d);
        bit exp_rdy;
        en1 = en; dr1 = dr; bus1.in_valid = v; bus1.in_data = d;
        #1;
        exp_rdy = m_ready(en);
        check("in_ready", bus1.in_ready, exp_rdy);
        if (v && bus1.in_ready) acc_seen++;
        last_acc = v && exp_rdy;
        m_step(en, dr, v, d);
        @(posedge clock);
        #1;
        cyc_no++;
        check("trigger", bus1.trigger, m_trig);
        check("frame_data", bus1.frame_data, m_frame);
        check("fifo_level", lvl1, m_fifo.size());
        check("frame_cnt", cnt1, m_cnt);
        check("done", done1, m_done);
        if (bus1.trigger) begin
            obs.push_back(bus1.frame_data);
            trig_seen++;
        end
    endtask

    initial begin
        int i, acc_cyc4, trig_cyc1, t2, over2, rdy_after, d2;
        bit acc2;
        logic [63:0] exp2;

        rst1 = 1; en1 = 1; dr1 = 0; bus1.in_valid = 0; bus1.in_data = '0;
        rst2 = 1; en2 = 1; dr2 = 1; bus2.in_valid = 0; bus2.in_data = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_in_ready", bus1.in_ready, 1'b0);
        check("rst_trigger", bus1.trigger, 1'b0);
        check("rst_frame", bus1.frame_data, 64'h0);
        check("rst_level", lvl1, 0);
        check("rst_cnt", cnt1, 0);
        check("rst_done", done1, 1'b0);
        rst1 = 0;
        m_reset();

        // Two frames with drain enabled, checking the first-trigger latency.
        obs.delete();
        i = 1; acc_cyc4 = -100; trig_cyc1 = -1;
        for (int k = 0; k < 40 && i <= 8; k++) begin
            cyc1(1, 1, 1, 16'(i));
            if (last_acc) begin
                if (i == 4) acc_cyc4 = cyc_no;
                i++;
            end
            if (bus1.trigger && trig_cyc1 < 0) trig_cyc1 = cyc_no;
        end
        repeat (6) cyc1(1, 1, 0, '0);
        check("t1_frames", obs.size(), 2);
        check("t1_first_latency", trig_cyc1 - acc_cyc4, 1);
        if (obs.size() == 2) begin
            check("t1_frame0", obs[0], 64'h0004_0003_0002_0001);
            check("t1_frame1", obs[1], 64'h0008_0007_0006_0005);
        end

        // FIFO fill with drain off, then drain.
        acc_seen = 0; i = 1;
        for (int k = 0; k < 60; k++) begin
            cyc1(1, 0, i <= 40, 16'(16'h0100 + i));
            if (last_acc) begin
                if (i == 32) check("t2_level_at_32", lvl1, 8);
                i++;
            end
        end
        check("t2_accepted", acc_seen, 35);
        trig_seen = 0;
        for (int k = 0; k < 16; k++) begin
            cyc1(1, 1, i <= 40, 16'(16'h0100 + i));
            if (last_acc) i++;
        end
        check("t2_drain_trigs", trig_seen, 8);
        for (int k = 0; k < 40; k++) begin
            cyc1(1, 1, i <= 40, 16'(16'h0100 + i));
            if (last_acc) i++;
        end
        check("t2_resumed", i, 41);

        // Enable gap in the middle of a frame.
        obs.delete();
        cyc1(1, 1, 1, 16'h0201);
        cyc1(1, 1, 1, 16'h0202);
        repeat (10) cyc1(0, 1, 1, 16'h0203);
        i = 3;
        for (int k = 0; k < 10 && i <= 4; k++) begin
            cyc1(1, 1, 1, 16'(16'h0200 + i));
            if (last_acc) i++;
        end
        repeat (4) cyc1(1, 1, 0, '0);
        check("t3_frames", obs.size(), 1);
        if (obs.size() >= 1) check("t3_frame", obs[0], 64'h0204_0203_0202_0201);

        // Randomized phases alternating drain pressure.
        for (int p = 0; p < 12; p++) begin
            for (int k = 0; k < 250; k++) begin
                cyc1($urandom_range(0, 9) != 0,
                     (p % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                     $urandom_range(0, 1),
                     16'($urandom));
            end
        end

        // Reset while a trigger is high and frames are buffered.
        rst1 = 1; #2; rst1 = 0;
        m_reset();
        for (int k = 0; k < 16; k++) cyc1(1, 0, 1, 16'(16'h0300 + k));
        cyc1(1, 1, 0, '0);
        check("t5_trig_before_rst", bus1.trigger, 1'b1);
        check("t5_level_before_rst", lvl1, 3);
        rst1 = 1;
        #1;
        check("t5_rst_trigger", bus1.trigger, 1'b0);
        check("t5_rst_frame", bus1.frame_data, 64'h0);
        check("t5_rst_level", lvl1, 0);
        check("t5_rst_cnt", cnt1, 0);
        check("t5_rst_done", done1, 1'b0);
        check("t5_rst_in_ready", bus1.in_ready, 1'b0);
        m_reset();
        @(posedge clock);
        #1;
        rst1 = 0;
        obs.delete();
        for (int k = 1; k <= 8; k++) cyc1(1, 1, 1, 16'(16'h0400 + k));
        repeat (6) cyc1(1, 1, 0, '0);
        check("t5_frames", obs.size(), 2);
        if (obs.size() == 2) begin
            check("t5_frame0", obs[0], 64'h0404_0403_0402_0401);
            check("t5_frame1", obs[1], 64'h0408_0407_0406_0405);
        end
        bus1.in_valid = 0;

        // Small instance: completion after three frames, FIFO depth two.
        #1;
        check("d2_rst_in_ready", bus2.in_ready, 1'b0);
        @(posedge clock);
        #1;
        rst2 = 0;
        t2 = 0; over2 = 0; rdy_after = 0; d2 = 1;
        for (int k = 0; k < 150; k++) begin
            bus2.in_valid = 1;
            bus2.in_data  = 16'(d2);
            #1;
            acc2 = bus2.in_ready;
            if (t2 >= D2_TT && acc2) rdy_after++;
            @(posedge clock);
            #1;
            if (acc2) d2++;
            if (lvl2 > 2) over2++;
            if (bus2.trigger) begin
                exp2 = {16'(4*t2 + 4), 16'(4*t2 + 3), 16'(4*t2 + 2), 16'(4*t2 + 1)};
                check("d2_frame", bus2.frame_data, exp2);
                t2++;
                if (t2 == 1) check("d2_done_early", done2, 1'b0);
                if (t2 == D2_TT) begin
                    check("d2_done", done2, 1'b1);
                    check("d2_cnt", cnt2, 3);
                end
            end
        end
        check("d2_trig_total", t2, 3);
        check("d2_ready_after_done", rdy_after, 0);
        check("d2_level_bound", over2, 0);
        check("d2_done_final", done2, 1'b1);
        check("d2_cnt_final", cnt2, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
